// File: rtl/ariscv_opfetch.sv
// ariscv_opfetch: operand-fetch / issue stage on the read side of the
// integer register file.
//
// Takes one decoded instruction at a time, drives the RF read addresses,
// waits out RAW/WAW hazards against a per-register busy scoreboard, forwards
// same-cycle writeback data, and offers the resolved operands to execute.
//
// Ports
//   clk, srst                     clock, synchronous active-high reset
//   in_valid/in_ready             decoded instruction handshake
//   in_rs1/in_rs2/in_rd/in_rd_we  decoded source/destination fields
//   rf_a1/rf_a2, rf_rd1/rf_rd2    RF read addresses and combinational data
//   wb_we/wb_a/wb_d               writeback (also drives the RF write port)
//   out_valid/out_ready           issue handshake to execute
//   out_op1/out_op2               resolved operands
//   out_rd/out_rd_we              destination passed through
//   stall_cnt                     saturating count of hazard-stall cycles
module ariscv_opfetch #(
  parameter int XLEN   = 32,
  parameter int MSB    = 4,
  parameter int NREG   = 32,
  parameter int SCNT_W = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MSB:0]      in_rs1,
  input  logic [MSB:0]      in_rs2,
  input  logic [MSB:0]      in_rd,
  input  logic              in_rd_we,
  output logic [MSB:0]      rf_a1,
  output logic [MSB:0]      rf_a2,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  logic [MSB:0]      wb_a,
  input  logic [XLEN-1:0]   wb_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [MSB:0]      out_rd,
  output logic              out_rd_we,
  output logic [SCNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, VALID} state_t;

  state_t st, st_nxt;

  // Stage p0: held instruction fields (captured in IDLE)
  logic [MSB:0]      rs1_p0, rs2_p0, rd_p0;
  logic              rd_we_p0;

  // Stage p1: resolved operands offered to execute
  logic [XLEN-1:0]   op1_p1, op2_p1;
  logic [MSB:0]      rd_p1;
  logic              rd_we_p1;
  logic              vld_p1;

  logic [NREG-1:0]   busy, busy_nxt;
  logic [SCNT_W-1:0] scnt;

  logic              fwd1, fwd2, raw1, raw2, waw, hazard, hs;
  logic [XLEN-1:0]   res1, res2;

  function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] v);
    return (&v) ? v : v + {{(SCNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] resolve(input logic [MSB:0] rs,
                                              input logic fwd,
                                              input logic [XLEN-1:0] rfd);
    if (rs == '0)
      return '0;
    else if (fwd)
      return wb_d;
    else
      return rfd;
  endfunction

  // The read addresses simply follow the held indices, so they keep the last
  // instruction's sources outside CHECK.
  assign rf_a1     = rs1_p0;
  assign rf_a2     = rs2_p0;
  assign out_op1   = op1_p1;
  assign out_op2   = op2_p1;
  assign out_rd    = rd_p1;
  assign out_rd_we = rd_we_p1;
  assign stall_cnt = scnt;

  // Hazard detection against the held instruction; x0 never forwards and is
  // never busy, and a writeback to the awaited register resolves the hazard
  // in the same cycle.
  always_comb begin
    fwd1   = wb_we && (wb_a == rs1_p0) && (rs1_p0 != '0);
    fwd2   = wb_we && (wb_a == rs2_p0) && (rs2_p0 != '0);
    raw1   = busy[rs1_p0] && !fwd1;
    raw2   = busy[rs2_p0] && !fwd2;
    waw    = rd_we_p0 && (rd_p0 != '0) && busy[rd_p0] && !(wb_we && (wb_a == rd_p0));
    hazard = raw1 || raw2 || waw;
    res1   = resolve(rs1_p0, fwd1, rf_rd1);
    res2   = resolve(rs2_p0, fwd2, rf_rd2);
  end

  always_comb begin
    st_nxt   = st;
    in_ready = 1'b0;
    vld_p1   = 1'b0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) st_nxt = CHECK;
      end
      CHECK: begin
        if (!hazard) st_nxt = VALID;
      end
      VALID: begin
        vld_p1 = 1'b1;
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign out_valid = vld_p1;
  assign hs        = vld_p1 && out_ready;

  // Clear first, then set, so an issuing producer wins over a writeback to
  // the same register at the same edge.
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < NREG; i++) begin
      if (wb_we && (wb_a == i[MSB:0])) busy_nxt[i] = 1'b0;
    end
    if (hs && rd_we_p1 && (rd_p1 != '0)) busy_nxt[rd_p1] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      st       <= IDLE;
      busy     <= '0;
      scnt     <= '0;
      rs1_p0   <= '0;
      rs2_p0   <= '0;
      rd_p0    <= '0;
      rd_we_p0 <= 1'b0;
      op1_p1   <= '0;
      op2_p1   <= '0;
      rd_p1    <= '0;
      rd_we_p1 <= 1'b0;
    end else begin
      st   <= st_nxt;
      busy <= busy_nxt;
      if (st == IDLE && in_valid) begin
        rs1_p0   <= in_rs1;
        rs2_p0   <= in_rs2;
        rd_p0    <= in_rd;
        rd_we_p0 <= in_rd_we;
      end
      if (st == CHECK) begin
        if (hazard) begin
          scnt <= sat_inc(scnt);
        end else begin
          op1_p1   <= res1;
          op2_p1   <= res2;
          rd_p1    <= rd_p0;
          rd_we_p1 <= rd_we_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ariscv_opfetch.sv
// Testbench for ariscv_opfetch: randomized and directed stimulus, expected
// responses queued at issue time from a program-order register model and
// checked by an independent monitor on each issue handshake.
module tb_ariscv_opfetch;

  localparam int XLEN   = 32;
  localparam int MSB    = 4;
  localparam int AW     = MSB + 1;
  localparam int NREG   = 32;
  localparam int SCNT_W = 16;

  logic              clk = 1'b0;
  logic              srst;
  logic              in_valid, in_ready;
  logic [MSB:0]      in_rs1, in_rs2, in_rd;
  logic              in_rd_we;
  logic [MSB:0]      rf_a1, rf_a2;
  logic [XLEN-1:0]   rf_rd1, rf_rd2;
  logic              wb_we;
  logic [MSB:0]      wb_a;
  logic [XLEN-1:0]   wb_d;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_op1, out_op2;
  logic [MSB:0]      out_rd;
  logic              out_rd_we;
  logic [SCNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  ariscv_opfetch #(.XLEN(XLEN), .MSB(MSB), .NREG(NREG), .SCNT_W(SCNT_W)) dut (
    .clk(clk), .srst(srst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_a(wb_a), .wb_d(wb_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .stall_cnt(stall_cnt)
  );

  // Bench register file (x0 returns garbage so the DUT must zero it itself)
  // and the architectural model in program order.
  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] mreg [NREG];

  always_comb begin
    rf_rd1 = (rf_a1 == '0) ? '1 : regs[rf_a1];
    rf_rd2 = (rf_a2 == '0) ? '1 : regs[rf_a2];
  end

  typedef struct {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [MSB:0]    rd;
    logic            rd_we;
    logic [XLEN-1:0] wbd;
  } exp_t;

  typedef struct {
    logic [MSB:0]    a;
    logic [XLEN-1:0] d;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wb_q[$];

  int n_chk = 0;
  int n_err = 0;
  bit auto_wb = 1'b0;
  bit stall_chk_en = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Monitor: scoreboard pop on handshake, hold stability, stall accounting.
  exp_t            e;
  wb_t             mw;
  int              chk_cyc = 0;
  longint          exp_stall = 0;
  logic            hold_prev = 1'b0;
  logic [XLEN-1:0] h1, h2;

  always @(negedge clk) begin
    if (!in_ready && !out_valid) chk_cyc++;
    if (out_valid && chk_cyc > 0) begin
      exp_stall += chk_cyc - 1;
      chk_cyc = 0;
      if (stall_chk_en)
        chk("stall_cnt_rand", stall_cnt, (exp_stall > 65535) ? 64'hFFFF : 64'(exp_stall));
    end
    if (out_valid && hold_prev) begin
      chk("hold_op1", out_op1, h1);
      chk("hold_op2", out_op2, h2);
    end
    if (out_valid && out_ready && !srst) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_issue actual=issue required=none");
      end else begin
        e = exp_q.pop_front();
        chk("op1", out_op1, e.op1);
        chk("op2", out_op2, e.op2);
        chk("rd", out_rd, e.rd);
        chk("rd_we", out_rd_we, e.rd_we);
        if (auto_wb && e.rd_we) begin
          mw.a = e.rd;
          mw.d = e.wbd;
          wb_q.push_back(mw);
        end
      end
    end
    hold_prev = out_valid && !(out_ready && !srst);
    h1 = out_op1;
    h2 = out_op2;
  end

  initial begin
    #960000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_we && wb_a != '0) regs[wb_a] = wb_d;
  endtask

  task automatic offer(input int rs1, input int rs2, input int rd, input bit we,
                       input logic [XLEN-1:0] wbd);
    exp_t x;
    x.op1   = (rs1 == 0) ? '0 : mreg[rs1];
    x.op2   = (rs2 == 0) ? '0 : mreg[rs2];
    x.rd    = AW'(rd);
    x.rd_we = we;
    x.wbd   = wbd;
    exp_q.push_back(x);
    if (we && rd != 0) mreg[rd] = wbd;
    in_valid = 1'b1;
    in_rs1   = AW'(rs1);
    in_rs2   = AW'(rs2);
    in_rd    = AW'(rd);
    in_rd_we = we;
  endtask

  task automatic issue_dir(input int rs1, input int rs2, input int rd, input bit we,
                           input logic [XLEN-1:0] wbd);
    chk("in_ready_before_issue", in_ready, 1);
    offer(rs1, rs2, rd, we, wbd);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    srst      = 1'b1;
    in_valid  = 1'b0;
    wb_we     = 1'b0;
    out_ready = 1'b0;
    tick();
    srst = 1'b0;
    exp_q.delete();
    wb_q.delete();
    for (int i = 0; i < NREG; i++) mreg[i] = regs[i];
  endtask

  task automatic do_wb(input int a, input logic [XLEN-1:0] d);
    wb_we = 1'b1;
    wb_a  = AW'(a);
    wb_d  = d;
    tick();
    wb_we = 1'b0;
  endtask

  int  issued;
  int  cyc;
  int  exp_sc;
  wb_t w;

  initial begin
    srst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
    wb_we = 1'b0; wb_a = '0; wb_d = '0; out_ready = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      regs[i] = $urandom;
      mreg[i] = regs[i];
    end
    tick();
    tick();
    srst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_out_op1", out_op1, 0);
    chk("rst_rf_a1", rf_a1, 0);

    // Randomized traffic with automatic writebacks
    auto_wb = 1'b1;
    stall_chk_en = 1'b1;
    issued = 0;
    cyc = 0;
    while ((issued < 200 || exp_q.size() != 0 || wb_q.size() != 0 || !in_ready) && cyc < 20000) begin
      tick();
      cyc++;
      in_valid = 1'b0;
      wb_we = 1'b0;
      out_ready = ($urandom_range(0, 9) < 7);
      if (wb_q.size() != 0 && $urandom_range(0, 2) != 0) begin
        w = wb_q.pop_front();
        wb_we = 1'b1; wb_a = w.a; wb_d = w.d;
      end else if ($urandom_range(0, 7) == 0) begin
        wb_we = 1'b1; wb_a = '0; wb_d = $urandom;
      end
      if (issued < 200 && in_ready && $urandom_range(0, 3) != 0) begin
        offer(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), $urandom);
        issued++;
      end
    end
    if (cyc >= 20000) begin
      n_chk++;
      n_err++;
      $display("FAIL random_phase actual=timeout required=drained");
    end
    tick();
    wb_we = 1'b0;
    in_valid = 1'b0;
    tick();
    auto_wb = 1'b0;
    stall_chk_en = 1'b0;

    // Directed: basic issue and latency
    do_reset();
    exp_sc = 0;
    regs[3] = 32'h11; mreg[3] = 32'h11;
    regs[5] = 32'h22; mreg[5] = 32'h22;
    out_ready = 1'b1;
    issue_dir(3, 5, 7, 1'b1, 32'hCAFEBABE);
    chk("t1_valid_e0", out_valid, 0);
    tick();
    chk("t1_valid_e1", out_valid, 1);
    tick();
    chk("t1_back_idle", in_ready, 1);

    // RAW on x7, resolved by forwarding
    issue_dir(7, 5, 8, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_sc++;
      chk("t2_stall_cnt", stall_cnt, exp_sc);
      chk("t2_no_valid", out_valid, 0);
    end
    do_wb(7, 32'hCAFEBABE);
    chk("t2_fwd_valid", out_valid, 1);
    chk("t2_cnt_hold", stall_cnt, exp_sc);
    tick();

    // x0 reads and writes
    issue_dir(0, 0, 0, 1'b1, 32'h5555AAAA);
    tick();
    chk("t3_x0_valid", out_valid, 1);
    tick();
    issue_dir(0, 7, 3, 1'b0, 32'h0);
    tick();
    chk("t3_no_stall", out_valid, 1);
    chk("t3_cnt", stall_cnt, exp_sc);
    tick();

    // WAW on x9, then set-wins against a coincident writeback
    issue_dir(1, 2, 9, 1'b1, 32'h0A0A0A0A);
    tick();
    tick();
    issue_dir(3, 3, 9, 1'b1, 32'h0B0B0B0B);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_sc++;
      chk("t4_waw_stall", stall_cnt, exp_sc);
      chk("t4_waw_no_valid", out_valid, 0);
    end
    do_wb(9, 32'h0A0A0A0A);
    chk("t4_waw_issue", out_valid, 1);
    do_wb(9, 32'h0C0C0C0C);
    issue_dir(9, 0, 10, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_sc++;
      chk("t4_setwins_stall", stall_cnt, exp_sc);
      chk("t4_setwins_no_valid", out_valid, 0);
    end
    do_wb(9, 32'h0B0B0B0B);
    chk("t4_fwd_valid", out_valid, 1);
    tick();

    // Back-pressure hold, then reset mid-VALID
    issue_dir(4, 4, 12, 1'b1, 32'h12121212);
    tick();
    tick();
    out_ready = 1'b0;
    issue_dir(3, 5, 0, 1'b0, 32'h0);
    tick();
    chk("t5_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_in_ready", in_ready, 0);
      chk("t5_hold_op1", out_op1, 32'h11);
      chk("t5_hold_op2", out_op2, 32'h22);
    end
    do_reset();
    exp_sc = 0;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    chk("t5_rst_stall_cnt", stall_cnt, 0);
    chk("t5_rst_op1", out_op1, 0);
    chk("t5_rst_op2", out_op2, 0);
    out_ready = 1'b1;
    issue_dir(12, 12, 0, 1'b0, 32'h0);
    tick();
    chk("t5_busy_cleared", out_valid, 1);
    chk("t5_cnt", stall_cnt, 0);
    tick();

    // Stall counter saturation
    issue_dir(13, 0, 13, 1'b1, 32'h13131313);
    tick();
    tick();
    issue_dir(13, 13, 0, 1'b0, 32'h0);
    for (int k = 0; k < 70000; k++) begin
      tick();
      if (k == 65533) chk("t6_near_sat", stall_cnt, 16'hFFFE);
    end
    chk("t6_sat", stall_cnt, 16'hFFFF);
    chk("t6_no_valid", out_valid, 0);
    do_wb(13, 32'h13131313);
    chk("t6_valid", out_valid, 1);
    chk("t6_sat_hold", stall_cnt, 16'hFFFF);
    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
